// File: rtl/mem_io_responder_if.sv
// Byte-serial memory port between the cache and the RAM/IO responder, plus the UART TX side.
// The master drives the request and tx_ready; the slave returns read data, FIFO and status outputs.
interface mem_io_responder_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  rdy_in;
    logic                  mem_rw;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic                  io_buffer_full;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic                  halt_req;
    logic                  tx_overflow;

    modport master (
        output rdy_in, mem_rw, mem_addr, mem_din, tx_ready,
        input  mem_dout, io_buffer_full, tx_valid, tx_data, halt_req, tx_overflow
    );

    modport slave (
        input  rdy_in, mem_rw, mem_addr, mem_din, tx_ready,
        output mem_dout, io_buffer_full, tx_valid, tx_data, halt_req, tx_overflow
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM with registered read data, plus an I/O window holding
// a TX byte FIFO toward the UART, a FIFO-status register and a sticky halt register.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 18,
    parameter int RAM_BITS   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_PTR_W = 3
) (
    input logic                clk_in,
    input logic                rst_in,
    mem_io_responder_if.slave  bus
);
    localparam int RAM_SIZE = 1 << RAM_BITS;
    localparam logic [FIFO_PTR_W:0] DEPTH_C   = FIFO_DEPTH[FIFO_PTR_W:0];
    localparam logic [FIFO_PTR_W:0] FULL_MARK = DEPTH_C - 1'b1;

    logic [7:0] ram_mem  [RAM_SIZE];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [7:0]            mem_dout_q, mem_dout_d;
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_W:0]   count_q, count_d;
    logic                  io_full_q, io_full_d;
    logic                  halt_q, halt_d;
    logic                  ovf_q, ovf_d;

    logic                  is_io;
    logic [2:0]            io_off;
    logic [RAM_BITS-1:0]   ram_idx;
    logic                  ram_wr;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  fifo_full;

    always_comb begin
        is_io     = (bus.mem_addr[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b11);
        io_off    = bus.mem_addr[2:0];
        ram_idx   = bus.mem_addr[RAM_BITS-1:0];
        ram_wr    = bus.rdy_in && !bus.mem_rw && !is_io;
        push_req  = bus.rdy_in && !bus.mem_rw && is_io && (io_off == 3'd0);
        // The pop side runs off tx_ready alone; rdy_in only freezes the cache-facing port.
        pop       = (count_q != '0) && bus.tx_ready;
        fifo_full = (count_q == DEPTH_C);
        // A full FIFO still takes a byte when the head leaves on the same edge.
        push_ok   = push_req && (!fifo_full || pop);

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // One slot of slack so the CPU's check-then-write never overruns.
        io_full_d = (count_d >= FULL_MARK);

        halt_d = halt_q | (bus.rdy_in && !bus.mem_rw && is_io && (io_off == 3'd4));
        ovf_d  = ovf_q  | (push_req && fifo_full && !pop);

        mem_dout_d = mem_dout_q;
        if (bus.rdy_in && bus.mem_rw) begin
            if (is_io) begin
                mem_dout_d = (io_off == 3'd4) ? {7'b0, io_full_q} : 8'h00;
            end else begin
                mem_dout_d = ram_mem[ram_idx];
            end
        end
    end

    // Storage arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram_mem[ram_idx] <= bus.mem_din;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= bus.mem_din;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_dout_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            io_full_q  <= 1'b0;
            halt_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mem_dout_q <= mem_dout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            io_full_q  <= io_full_d;
            halt_q     <= halt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.mem_dout       = mem_dout_q;
    assign bus.io_buffer_full = io_full_q;
    assign bus.tx_valid       = (count_q != '0);
    // Gated so an empty FIFO presents zero rather than stale or uninitialised storage.
    assign bus.tx_data        = (count_q != '0) ? fifo_mem[rd_ptr_q] : 8'h00;
    assign bus.halt_req       = halt_q;
    assign bus.tx_overflow    = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized checks of mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;
    localparam int AW = 18;
    localparam logic [AW-1:0] IDLE_ADDR = 18'h30001;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    mem_io_responder_if #(.ADDR_WIDTH(AW)) bus ();

    mem_io_responder #(
        .ADDR_WIDTH(AW), .RAM_BITS(16), .FIFO_DEPTH(8), .FIFO_PTR_W(3)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit   [7:0] ram_m [int];
    logic [7:0] fifo_m [$];
    logic       halt_m, ovf_m, full_m;
    logic [7:0] dout_m;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic drive(input bit rdy, input bit rw, input logic [AW-1:0] a,
                         input logic [7:0] d, input bit txr);
        bus.rdy_in   = rdy;
        bus.mem_rw   = rw;
        bus.mem_addr = a;
        bus.mem_din  = d;
        bus.tx_ready = txr;
    endtask

    task automatic reset_model();
        fifo_m.delete();
        halt_m = 1'b0;
        ovf_m  = 1'b0;
        full_m = 1'b0;
        dout_m = 8'h00;
    endtask

    // Applies the effect of the upcoming edge, using the inputs currently driven.
    task automatic model_step();
        bit io, pop, accept;
        int off, idx;
        io     = (bus.mem_addr[AW-1:AW-2] == 2'b11);
        off    = int'(bus.mem_addr[2:0]);
        idx    = int'(bus.mem_addr[15:0]);
        pop    = (fifo_m.size() > 0) && bus.tx_ready;
        accept = 1'b0;
        if (bus.rdy_in) begin
            if (bus.mem_rw) begin
                if (io) dout_m = (off == 4) ? {7'b0, full_m} : 8'h00;
                else    dout_m = ram_m[idx];
            end else if (!io) begin
                ram_m[idx] = bus.mem_din;
            end else if (off == 0) begin
                if (fifo_m.size() < 8 || pop) accept = 1'b1;
                else ovf_m = 1'b1;
            end else if (off == 4) begin
                halt_m = 1'b1;
            end
        end
        if (pop) void'(fifo_m.pop_front());
        if (accept) fifo_m.push_back(bus.mem_din);
        full_m = (fifo_m.size() >= 7);
    endtask

    task automatic check_all();
        check("mem_dout", bus.mem_dout, dout_m);
        check("tx_valid", bus.tx_valid, fifo_m.size() > 0);
        check("tx_data", bus.tx_data, (fifo_m.size() > 0) ? fifo_m[0] : 8'h00);
        check("io_buffer_full", bus.io_buffer_full, full_m);
        check("halt_req", bus.halt_req, halt_m);
        check("tx_overflow", bus.tx_overflow, ovf_m);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
        check_all();
    endtask

    // Asserts reset between edges and releases it just after the next edge.
    task automatic pulse_reset();
        #2;
        rst_in = 1'b0;
        #1;
        reset_model();
        check_all();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        rst_in = 1'b0;
        drive(1'b1, 1'b1, IDLE_ADDR, 8'h00, 1'b0);
        reset_model();
        repeat (2) @(posedge clk_in);
        #1;
        check_all();
        rst_in = 1'b1;

        // Test 1: write then read back with one-cycle latency.
        drive(1'b1, 1'b0, 18'h00123, 8'hA5, 1'b0); tick();
        drive(1'b1, 1'b1, 18'h00123, 8'h00, 1'b0); tick();
        check("t1_read_a5", bus.mem_dout, 8'hA5);

        // Preload the streaming block and the random-phase region.
        drive(1'b1, 1'b0, 18'h00100, 8'h11, 1'b0); tick();
        drive(1'b1, 1'b0, 18'h00101, 8'h22, 1'b0); tick();
        drive(1'b1, 1'b0, 18'h00102, 8'h33, 1'b0); tick();
        drive(1'b1, 1'b0, 18'h00103, 8'h44, 1'b0); tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 18'h00200 + 18'(i), 8'($urandom), 1'b0); tick();
        end

        // Test 2: streaming reads with a two-cycle rdy_in stall.
        drive(1'b1, 1'b1, 18'h00100, 8'h00, 1'b0); tick(); check("t2_s0", bus.mem_dout, 8'h11);
        drive(1'b1, 1'b1, 18'h00101, 8'h00, 1'b0); tick(); check("t2_s1", bus.mem_dout, 8'h22);
        drive(1'b0, 1'b1, 18'h00102, 8'h00, 1'b0); tick(); check("t2_hold0", bus.mem_dout, 8'h22);
        tick(); check("t2_hold1", bus.mem_dout, 8'h22);
        drive(1'b1, 1'b1, 18'h00102, 8'h00, 1'b0); tick(); check("t2_s2", bus.mem_dout, 8'h33);
        drive(1'b1, 1'b1, 18'h00103, 8'h00, 1'b0); tick(); check("t2_s3", bus.mem_dout, 8'h44);

        // Test 3: fill past capacity, then drain in order.
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 1'b0, 18'h30000, 8'(i), 1'b0); tick();
            check("t3_full_flag", bus.io_buffer_full, i >= 7);
        end
        check("t3_overflow", bus.tx_overflow, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b1, IDLE_ADDR, 8'h00, 1'b1);
            check("t3_drain", bus.tx_data, 8'(k));
            tick();
        end
        check("t3_empty", bus.tx_valid, 8'h00);

        pulse_reset();

        // Test 4: push onto a full FIFO while the head pops on the same edge.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 18'h30000, 8'h10 + 8'(i), 1'b0); tick();
        end
        drive(1'b1, 1'b0, 18'h30000, 8'h5A, 1'b1); tick();
        check("t4_no_overflow", bus.tx_overflow, 8'h00);
        check("t4_head", bus.tx_data, 8'h11);
        check("t4_still_full", bus.io_buffer_full, 8'h01);

        // Test 5: status read, halt write, TX data-register read.
        drive(1'b1, 1'b1, IDLE_ADDR, 8'h00, 1'b1); tick();
        drive(1'b1, 1'b1, 18'h30004, 8'h00, 1'b0); tick();
        check("t5_status", bus.mem_dout, 8'h01);
        drive(1'b1, 1'b0, 18'h30004, 8'h00, 1'b0); tick();
        check("t5_halt", bus.halt_req, 8'h01);
        drive(1'b1, 1'b1, 18'h30000, 8'h00, 1'b0); tick();
        check("t5_txreg_read", bus.mem_dout, 8'h00);
        check("t5_fifo_kept", bus.tx_data, 8'h12);
        check("t5_halt_hold", bus.halt_req, 8'h01);

        // Test 6: asynchronous reset mid-drain with three bytes left.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, IDLE_ADDR, 8'h00, 1'b1); tick();
        end
        check("t6_pre_head", bus.tx_data, 8'h16);
        pulse_reset();
        check("t6_rst_valid", bus.tx_valid, 8'h00);
        check("t6_rst_halt", bus.halt_req, 8'h00);
        drive(1'b1, 1'b1, 18'h00123, 8'h00, 1'b0); tick();
        check("t6_ram_kept", bus.mem_dout, 8'hA5);

        // Randomized traffic over the preloaded RAM region (with aliasing) and the I/O window.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    a = {2'b11, 13'($urandom), 3'd0};
                    2:       a = {2'b11, 13'($urandom), 3'd4};
                    default: a = {2'b11, 13'($urandom), 3'($urandom_range(0, 7))};
                endcase
            end else begin
                a = {2'($urandom_range(0, 2)), 16'h0200 + 16'($urandom_range(0, 31))};
            end
            drive($urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)), a,
                  8'($urandom), $urandom_range(0, 99) < 30);
            tick();
            if (n == 300) pulse_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
